// File: rtl/mem_stage_pkg.sv
// Shared pipeline types for the MEM stage: access-size encodings and the
// EX/MEM and MEM/WB register layouts.
package mem_stage_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
    } ex_mem_t;

    // The loaded word itself is held in the data memory's read register.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
        logic [1:0]  lane;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        misalign;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-wide data memory with byte-enable writes and an enabled synchronous read.
// Optional asynchronous debug read port when MEM_DEBUG_PORT_EN is defined.
module data_memory #(
    parameter  int MEM_DEPTH = 256,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [31:0]       o_dbg_data
`endif
);

    logic [31:0] r_mem [MEM_DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Read register is the MEM/WB copy of the loaded word, so it resets with the stage.
    always_ff @(posedge i_clk) begin
        if (!i_reset)  r_rdata <= '0;
        else if (i_en) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

`ifdef MEM_DEBUG_PORT_EN
    assign o_dbg_data = r_mem[i_dbg_addr];
`endif

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, byte-lane load/store to data memory,
// MEM/WB register and write-back mux. MEM_DEBUG_PORT_EN adds a debug read port.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter  int MEM_DEPTH = 256,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_halt,
    input  logic [31:0] i_ex_alu_result,
    input  logic [31:0] i_ex_write_data,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_mem_read,
    input  logic        i_ex_mem_write,
    input  logic        i_ex_mem_to_reg,
    input  logic        i_ex_reg_write,
    input  logic [1:0]  i_ex_mem_size,
    input  logic        i_ex_mem_unsigned,
    output logic [31:0] o_ex_m_alu_result,
    output logic [4:0]  o_ex_m_rd,
    output logic        o_ex_m_reg_write,
    output logic [31:0] o_m_wb_data_write,
    output logic [4:0]  o_m_wb_rd,
    output logic        o_m_wb_reg_write,
    output logic        o_misalign
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [31:0]       o_dbg_data
`endif
);

    ex_mem_t     r_ex;
    mem_wb_t     r_wb;
    logic        r_misalign;

    logic [1:0]  w_lane;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_we;
    logic        w_rd_en;
    logic [31:0] w_rd_word;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_ex <= '0;
        end else if (!i_halt) begin
            r_ex <= '{alu_result:   i_ex_alu_result,
                      write_data:   i_ex_write_data,
                      rd:           i_ex_rd,
                      mem_read:     i_ex_mem_read,
                      mem_write:    i_ex_mem_write,
                      mem_to_reg:   i_ex_mem_to_reg,
                      reg_write:    i_ex_reg_write,
                      mem_size:     i_ex_mem_size,
                      mem_unsigned: i_ex_mem_unsigned};
        end
    end

    assign w_lane     = r_ex.alu_result[1:0];
    assign w_misalign = ((r_ex.mem_size == MEM_HALF) && w_lane[0]) ||
                        (r_ex.mem_size[1] && (w_lane != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_ex.write_data;
        case (r_ex.mem_size)
            MEM_BYTE: begin
                w_wdata = {4{r_ex.write_data[7:0]}};
                w_be    = 4'b0001 << w_lane;
            end
            MEM_HALF: begin
                w_wdata = {2{r_ex.write_data[15:0]}};
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // A reset edge must never commit the store sitting in EX/MEM.
    assign w_we    = r_ex.mem_write && !w_misalign && !i_halt && i_reset;
    assign w_rd_en = !i_halt;

    data_memory #(.MEM_DEPTH(MEM_DEPTH)) u_data_memory (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_en       (w_rd_en),
        .i_we       (w_we),
        .i_be       (w_be),
        .i_addr     (r_ex.alu_result[ADDR_W+1:2]),
        .i_wdata    (w_wdata),
        .o_rdata    (w_rd_word)
`ifdef MEM_DEBUG_PORT_EN
        ,
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
`endif
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wb       <= '0;
            r_misalign <= 1'b0;
        end else if (!i_halt) begin
            r_wb <= '{alu_result:   r_ex.alu_result,
                      rd:           r_ex.rd,
                      reg_write:    r_ex.reg_write,
                      mem_to_reg:   r_ex.mem_to_reg,
                      lane:         w_lane,
                      mem_size:     r_ex.mem_size,
                      mem_unsigned: r_ex.mem_unsigned,
                      misalign:     w_misalign};
            if (w_misalign && (r_ex.mem_read || r_ex.mem_write)) r_misalign <= 1'b1;
        end
    end

    always_comb begin
        case (r_wb.lane)
            2'd0:    w_ld_byte = w_rd_word[7:0];
            2'd1:    w_ld_byte = w_rd_word[15:8];
            2'd2:    w_ld_byte = w_rd_word[23:16];
            default: w_ld_byte = w_rd_word[31:24];
        endcase
        w_ld_half = r_wb.lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    end

    always_comb begin
        w_ld_data = w_rd_word;
        case (r_wb.mem_size)
            MEM_BYTE: w_ld_data = r_wb.mem_unsigned ? {24'h0, w_ld_byte}
                                                    : {{24{w_ld_byte[7]}}, w_ld_byte};
            MEM_HALF: w_ld_data = r_wb.mem_unsigned ? {16'h0, w_ld_half}
                                                    : {{16{w_ld_half[15]}}, w_ld_half};
            default:  ;
        endcase
        if (r_wb.misalign) w_ld_data = '0;
    end

    assign o_ex_m_alu_result = r_ex.alu_result;
    assign o_ex_m_rd         = r_ex.rd;
    assign o_ex_m_reg_write  = r_ex.reg_write;
    assign o_m_wb_data_write = r_wb.mem_to_reg ? w_ld_data : r_wb.alu_result;
    assign o_m_wb_rd         = r_wb.rd;
    assign o_m_wb_reg_write  = r_wb.reg_write;
    assign o_misalign        = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a reference memory model predicts EX/MEM and
// MEM/WB outputs per issued instruction; halted edges delay the queued results.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset, i_halt;
    logic [31:0] i_ex_alu_result, i_ex_write_data;
    logic [4:0]  i_ex_rd;
    logic        i_ex_mem_read, i_ex_mem_write, i_ex_mem_to_reg, i_ex_reg_write;
    logic [1:0]  i_ex_mem_size;
    logic        i_ex_mem_unsigned;
    logic [31:0] o_ex_m_alu_result, o_m_wb_data_write;
    logic [4:0]  o_ex_m_rd, o_m_wb_rd;
    logic        o_ex_m_reg_write, o_m_wb_reg_write, o_misalign;
`ifdef MEM_DEBUG_PORT_EN
    logic [7:0]  i_dbg_addr = '0;
    logic [31:0] o_dbg_data;
`endif

    always #5 i_clk = ~i_clk;

    mem_stage #(.MEM_DEPTH(256)) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_halt            (i_halt),
        .i_ex_alu_result   (i_ex_alu_result),
        .i_ex_write_data   (i_ex_write_data),
        .i_ex_rd           (i_ex_rd),
        .i_ex_mem_read     (i_ex_mem_read),
        .i_ex_mem_write    (i_ex_mem_write),
        .i_ex_mem_to_reg   (i_ex_mem_to_reg),
        .i_ex_reg_write    (i_ex_reg_write),
        .i_ex_mem_size     (i_ex_mem_size),
        .i_ex_mem_unsigned (i_ex_mem_unsigned),
        .o_ex_m_alu_result (o_ex_m_alu_result),
        .o_ex_m_rd         (o_ex_m_rd),
        .o_ex_m_reg_write  (o_ex_m_reg_write),
        .o_m_wb_data_write (o_m_wb_data_write),
        .o_m_wb_rd         (o_m_wb_rd),
        .o_m_wb_reg_write  (o_m_wb_reg_write),
        .o_misalign        (o_misalign)
`ifdef MEM_DEBUG_PORT_EN
        ,
        .i_dbg_addr        (i_dbg_addr),
        .o_dbg_data        (o_dbg_data)
`endif
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        string       tag;
    } exp_t;

    exp_t        q_ex[$];
    exp_t        q_wb[$];
    logic [31:0] mdl [256];
    logic        exp_sticky = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    exp_t e;
    always @(posedge i_clk) begin
        cyc++;
        if (i_reset && i_halt) begin
            foreach (q_ex[i]) q_ex[i].due++;
            foreach (q_wb[i]) q_wb[i].due++;
        end
        #1;
        while (q_ex.size() > 0 && q_ex[0].due == cyc) begin
            e = q_ex.pop_front();
            chk({e.tag, ".ex_alu"}, o_ex_m_alu_result, e.data);
            chk({e.tag, ".ex_rd"},  {27'b0, o_ex_m_rd}, {27'b0, e.rd});
            chk({e.tag, ".ex_rw"},  {31'b0, o_ex_m_reg_write}, {31'b0, e.rw});
        end
        while (q_wb.size() > 0 && q_wb[0].due == cyc) begin
            e = q_wb.pop_front();
            chk({e.tag, ".wb_data"}, o_m_wb_data_write, e.data);
            chk({e.tag, ".wb_rd"},   {27'b0, o_m_wb_rd}, {27'b0, e.rd});
            chk({e.tag, ".wb_rw"},   {31'b0, o_m_wb_reg_write}, {31'b0, e.rw});
            chk({e.tag, ".misalign"}, {31'b0, o_misalign}, {31'b0, e.mis});
        end
    end

    // Drive one instruction at a falling edge, predict its results, advance one cycle.
    task automatic issue(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rdm, input logic wr,
                         input logic m2r, input logic rw, input logic [1:0] sz,
                         input logic uns);
        logic [7:0]  idx;
        logic        mis;
        logic [31:0] w, ld;
        logic [7:0]  b;
        logic [15:0] h;
        int          lane;
        exp_t        x;
        i_ex_alu_result   = alu;
        i_ex_write_data   = wd;
        i_ex_rd           = rd;
        i_ex_mem_read     = rdm;
        i_ex_mem_write    = wr;
        i_ex_mem_to_reg   = m2r;
        i_ex_reg_write    = rw;
        i_ex_mem_size     = sz;
        i_ex_mem_unsigned = uns;
        idx  = alu[9:2];
        lane = int'(alu[1:0]);
        mis  = (sz == MEM_HALF && alu[0]) || (sz[1] && alu[1:0] != 2'b00);
        w    = mdl[idx];
        if (wr && !mis) begin
            if (sz == MEM_BYTE)      w[lane*8 +: 8] = wd[7:0];
            else if (sz == MEM_HALF) w[(alu[1] ? 16 : 0) +: 16] = wd[15:0];
            else                     w = wd;
            mdl[idx] = w;
        end
        b = w[lane*8 +: 8];
        h = alu[1] ? w[31:16] : w[15:0];
        if (sz == MEM_BYTE)      ld = uns ? {24'h0, b} : {{24{b[7]}}, b};
        else if (sz == MEM_HALF) ld = uns ? {16'h0, h} : {{16{h[15]}}, h};
        else                     ld = w;
        if (mis) ld = '0;
        if ((rdm || wr) && mis) exp_sticky = 1'b1;
        x.tag = tag; x.rd = rd; x.rw = rw; x.mis = exp_sticky;
        x.due = cyc + 1; x.data = alu;
        q_ex.push_back(x);
        x.due = cyc + 2; x.data = m2r ? ld : alu;
        q_wb.push_back(x);
        @(negedge i_clk);
    endtask

    task automatic hold(input int n);
        logic [31:0] s_alu, s_wb;
        logic [4:0]  s_rd, s_wbrd;
        logic        s_mis;
        s_alu = o_ex_m_alu_result; s_rd = o_ex_m_rd;
        s_wb  = o_m_wb_data_write; s_wbrd = o_m_wb_rd; s_mis = o_misalign;
        i_halt            = 1'b1;
        i_ex_alu_result   = $urandom;
        i_ex_write_data   = $urandom;
        i_ex_rd           = 5'($urandom_range(0, 31));
        i_ex_mem_write    = 1'b1;
        i_ex_mem_read     = 1'b1;
        i_ex_mem_size     = MEM_WORD;
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            chk("halt.ex_alu",  o_ex_m_alu_result, s_alu);
            chk("halt.ex_rd",   {27'b0, o_ex_m_rd}, {27'b0, s_rd});
            chk("halt.wb_data", o_m_wb_data_write, s_wb);
            chk("halt.wb_rd",   {27'b0, o_m_wb_rd}, {27'b0, s_wbrd});
            chk("halt.mis",     {31'b0, o_misalign}, {31'b0, s_mis});
        end
        i_halt = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".ex_alu"},  o_ex_m_alu_result, 32'h0);
        chk({tag, ".ex_rd"},   {27'b0, o_ex_m_rd}, 32'h0);
        chk({tag, ".ex_rw"},   {31'b0, o_ex_m_reg_write}, 32'h0);
        chk({tag, ".wb_data"}, o_m_wb_data_write, 32'h0);
        chk({tag, ".wb_rd"},   {27'b0, o_m_wb_rd}, 32'h0);
        chk({tag, ".wb_rw"},   {31'b0, o_m_wb_reg_write}, 32'h0);
        chk({tag, ".mis"},     {31'b0, o_misalign}, 32'h0);
    endtask

    initial begin
        int guard;
        foreach (mdl[i]) mdl[i] = '0;
        i_reset = 1'b0; i_halt = 1'b0;
        i_ex_alu_result = '0; i_ex_write_data = '0; i_ex_rd = '0;
        i_ex_mem_read = 0; i_ex_mem_write = 0; i_ex_mem_to_reg = 0; i_ex_reg_write = 0;
        i_ex_mem_size = MEM_BYTE; i_ex_mem_unsigned = 0;
        repeat (2) @(negedge i_clk);
        check_zero("reset");
        i_reset = 1'b1;

        //     tag        alu           wdata         rd  rd wr m2r rw size      uns
        issue("idle0",   32'h0,        32'h0,        0,  0, 0, 0,  0, MEM_BYTE, 0);
        issue("idle1",   32'h0,        32'h0,        0,  0, 0, 0,  0, MEM_BYTE, 0);
        issue("st_w",    32'h10,       32'hDEADBEEF, 0,  0, 1, 0,  0, MEM_WORD, 0);
        issue("ld_w",    32'h10,       32'h0,        5,  1, 0, 1,  1, MEM_WORD, 0);
        issue("st_b",    32'h13,       32'h00000080, 0,  0, 1, 0,  0, MEM_BYTE, 0);
        issue("ld_bs",   32'h13,       32'h0,        1,  1, 0, 1,  1, MEM_BYTE, 0);
        issue("ld_bu",   32'h13,       32'h0,        2,  1, 0, 1,  1, MEM_BYTE, 1);
        issue("ld_w2",   32'h10,       32'h0,        3,  1, 0, 1,  1, MEM_WORD, 0);
        issue("ld_hs",   32'h12,       32'h0,        4,  1, 0, 1,  1, MEM_HALF, 0);
        issue("st_h",    32'h12,       32'h00001234, 0,  0, 1, 0,  0, MEM_HALF, 0);
        issue("ld_hmis", 32'h11,       32'h0,        6,  1, 0, 1,  1, MEM_HALF, 0);
        issue("st_wmis", 32'h11,       32'hFFFFFFFF, 0,  0, 1, 0,  0, MEM_WORD, 0);
        issue("ld_w3",   32'h10,       32'h0,        7,  1, 0, 1,  1, MEM_WORD, 0);
        issue("ld_hu",   32'h12,       32'h0,        8,  1, 0, 1,  1, MEM_HALF, 1);
        issue("st_w20",  32'h20,       32'h11111111, 0,  0, 1, 0,  0, MEM_WORD, 0);
        issue("st_bhlt", 32'h20,       32'h000000AB, 0,  0, 1, 0,  0, MEM_BYTE, 0);
        hold(3);
        issue("ld_w20",  32'h20,       32'h0,        10, 1, 0, 1,  1, MEM_WORD, 0);
        issue("rtype",   32'h7,        32'h0,        9,  0, 0, 0,  1, MEM_WORD, 0);
        issue("st_alias",32'h410,      32'hCAFEF00D, 0,  0, 1, 0,  0, MEM_WORD, 0);
        issue("ld_alias",32'h10,       32'h0,        11, 1, 0, 1,  1, MEM_WORD, 0);
        issue("ld_b0",   32'h10,       32'h0,        12, 1, 0, 1,  1, MEM_BYTE, 0);

        i_ex_mem_read = 0; i_ex_mem_write = 0; i_ex_mem_to_reg = 0; i_ex_reg_write = 0;
        guard = 0;
        while ((q_ex.size() > 0 || q_wb.size() > 0) && guard < 20) begin
            @(negedge i_clk);
            guard++;
        end
        chk("drain", q_wb.size(), 0);

        i_halt = 1'b1; i_reset = 1'b0;
        @(negedge i_clk);
        check_zero("rst_halt");
        i_reset = 1'b1; i_halt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
